// File: rtl/tlc_request_unit.sv
// tlc_request_unit: synchronises/debounces the pedestrian button and vehicle loops,
// latches pedestrian requests until the light FSM answers with walk, and times the wait.
module tlc_request_unit #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int WAIT_W       = 5,
    parameter int MAX_WAIT     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ped_btn_raw,
    input  logic              ns_sensor_raw,
    input  logic              ew_sensor_raw,
    input  logic              walk,
    output logic              NS,
    output logic              EW,
    output logic              Pedestrian,
    output logic [WAIT_W-1:0] ped_wait_cnt,
    output logic              ped_overdue
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [1:0] {IDLE, PENDING, SERVING} state_t;

    state_t        state;
    logic          again;
    logic [2:0]    raw, s1, s2, stable, accept;
    logic [CW-1:0] cnt [3];
    logic          press;

    assign raw = {ped_btn_raw, ew_sensor_raw, ns_sensor_raw};

    always_comb
        for (int i = 0; i < 3; i++)
            accept[i] = (s2[i] != stable[i]) && (cnt[i] == CW'(DEBOUNCE_CYC - 1));

    // A press is the debounced button being accepted high on this edge, so the
    // request registers on the same edge the button becomes stable.
    assign press = accept[2] & s2[2];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == stable[i]) cnt[i] <= '0;
                else if (accept[i]) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else cnt[i] <= cnt[i] + CW'(1);
            end
        end

    assign NS = stable[0];
    assign EW = stable[1];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state        <= IDLE;
            Pedestrian   <= 1'b0;
            ped_wait_cnt <= '0;
            again        <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (press && !walk) begin
                        state      <= PENDING;
                        Pedestrian <= 1'b1;
                    end
                PENDING:
                    if (walk) begin
                        state      <= SERVING;
                        Pedestrian <= 1'b0;
                    end else if (ped_wait_cnt != {WAIT_W{1'b1}})
                        ped_wait_cnt <= ped_wait_cnt + WAIT_W'(1);
                SERVING:
                    if (!walk) begin
                        again <= 1'b0;
                        ped_wait_cnt <= '0;
                        if (again || press) begin
                            state      <= PENDING;
                            Pedestrian <= 1'b1;
                        end else state <= IDLE;
                    end else if (press) again <= 1'b1;
                default: begin
                    state      <= IDLE;
                    Pedestrian <= 1'b0;
                    again      <= 1'b0;
                end
            endcase
        end

    assign ped_overdue = (state == PENDING) && (ped_wait_cnt >= WAIT_W'(MAX_WAIT));
endmodule

// File: tb/tb_tlc_request_unit.sv
// tb_tlc_request_unit: directed tests of debounce, pedestrian latching, wait timing and reset.
module tb_tlc_request_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ped_btn_raw = 1'b0;
    logic       ns_sensor_raw = 1'b0;
    logic       ew_sensor_raw = 1'b0;
    logic       walk = 1'b0;
    logic       NS, EW, Pedestrian, ped_overdue;
    logic [4:0] ped_wait_cnt;
    int         n_tests = 0;
    int         n_fail = 0;

    tlc_request_unit dut (
        .clk(clk), .rst(rst), .ped_btn_raw(ped_btn_raw), .ns_sensor_raw(ns_sensor_raw),
        .ew_sensor_raw(ew_sensor_raw), .walk(walk), .NS(NS), .EW(EW), .Pedestrian(Pedestrian),
        .ped_wait_cnt(ped_wait_cnt), .ped_overdue(ped_overdue)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        tick(2);
        n_tests++; if ({NS, EW, Pedestrian, ped_overdue} !== 4'b0) begin n_fail++; $display("FAIL reset_outs got=%b exp=0000", {NS, EW, Pedestrian, ped_overdue}); end
        n_tests++; if (ped_wait_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", ped_wait_cnt); end
        #3 rst = 1'b0;
        tick(1);
    endtask

    task automatic test_ns_debounce;
        ns_sensor_raw = 1'b1;
        tick(3);
        ns_sensor_raw = 1'b0;
        tick(8);
        n_tests++; if (NS !== 1'b0) begin n_fail++; $display("FAIL ns_short_pulse got=%b exp=0", NS); end
        ns_sensor_raw = 1'b1;
        tick(5);
        n_tests++; if (NS !== 1'b0) begin n_fail++; $display("FAIL ns_edge4 got=%b exp=0", NS); end
        tick(1);
        n_tests++; if (NS !== 1'b1) begin n_fail++; $display("FAIL ns_edge5 got=%b exp=1", NS); end
        for (int i = 0; i < 4; i++) begin
            ns_sensor_raw = i[0];
            tick(1);
        end
        ns_sensor_raw = 1'b1;
        tick(8);
        n_tests++; if (NS !== 1'b1) begin n_fail++; $display("FAIL ns_bounce got=%b exp=1", NS); end
        n_tests++; if (EW !== 1'b0) begin n_fail++; $display("FAIL ew_untouched got=%b exp=0", EW); end
        ns_sensor_raw = 1'b0;
        tick(5);
        n_tests++; if (NS !== 1'b1) begin n_fail++; $display("FAIL ns_fall_edge4 got=%b exp=1", NS); end
        tick(1);
        n_tests++; if (NS !== 1'b0) begin n_fail++; $display("FAIL ns_fall_edge5 got=%b exp=0", NS); end
    endtask

    task automatic test_ped_request;
        ped_btn_raw = 1'b1;
        tick(5);
        n_tests++; if (Pedestrian !== 1'b0) begin n_fail++; $display("FAIL ped_edge4 got=%b exp=0", Pedestrian); end
        tick(1);
        n_tests++; if (Pedestrian !== 1'b1) begin n_fail++; $display("FAIL ped_edge5 got=%b exp=1", Pedestrian); end
        n_tests++; if (ped_wait_cnt !== 5'd0) begin n_fail++; $display("FAIL ped_cnt_start got=%0d exp=0", ped_wait_cnt); end
        tick(4);
        ped_btn_raw = 1'b0;
        n_tests++; if (ped_wait_cnt !== 5'd4) begin n_fail++; $display("FAIL ped_cnt4 got=%0d exp=4", ped_wait_cnt); end
        tick(6);
        n_tests++; if (Pedestrian !== 1'b1) begin n_fail++; $display("FAIL ped_latched got=%b exp=1", Pedestrian); end
        n_tests++; if (ped_wait_cnt !== 5'd10) begin n_fail++; $display("FAIL ped_cnt10 got=%0d exp=10", ped_wait_cnt); end
        walk = 1'b1;
        tick(1);
        n_tests++; if (Pedestrian !== 1'b0) begin n_fail++; $display("FAIL ped_served got=%b exp=0", Pedestrian); end
        n_tests++; if (ped_wait_cnt !== 5'd10) begin n_fail++; $display("FAIL ped_cnt_hold got=%0d exp=10", ped_wait_cnt); end
        tick(1);
        walk = 1'b0;
        tick(1);
        n_tests++; if ({Pedestrian, ped_wait_cnt} !== 6'd0) begin n_fail++; $display("FAIL ped_idle got=%b/%0d exp=0/0", Pedestrian, ped_wait_cnt); end
    endtask

    task automatic test_again;
        ped_btn_raw = 1'b1;
        tick(6);
        ped_btn_raw = 1'b0;
        tick(6);
        walk = 1'b1;
        tick(1);
        ped_btn_raw = 1'b1;
        tick(6);
        ped_btn_raw = 1'b0;
        n_tests++; if (Pedestrian !== 1'b0) begin n_fail++; $display("FAIL again_serving got=%b exp=0", Pedestrian); end
        n_tests++; if (ped_wait_cnt !== 5'd6) begin n_fail++; $display("FAIL again_cnt_hold got=%0d exp=6", ped_wait_cnt); end
        walk = 1'b0;
        tick(1);
        n_tests++; if (Pedestrian !== 1'b1) begin n_fail++; $display("FAIL again_reassert got=%b exp=1", Pedestrian); end
        n_tests++; if (ped_wait_cnt !== 5'd0) begin n_fail++; $display("FAIL again_cnt_restart got=%0d exp=0", ped_wait_cnt); end
        tick(1);
        n_tests++; if (ped_wait_cnt !== 5'd1) begin n_fail++; $display("FAIL again_cnt1 got=%0d exp=1", ped_wait_cnt); end
        walk = 1'b1;
        tick(1);
        walk = 1'b0;
        tick(6);
        n_tests++; if (Pedestrian !== 1'b0) begin n_fail++; $display("FAIL again_done got=%b exp=0", Pedestrian); end
    endtask

    task automatic test_overdue;
        ped_btn_raw = 1'b1;
        tick(6);
        ped_btn_raw = 1'b0;
        tick(14);
        n_tests++; if ({ped_overdue, ped_wait_cnt} !== {1'b0, 5'd14}) begin n_fail++; $display("FAIL overdue_14 got=%b/%0d exp=0/14", ped_overdue, ped_wait_cnt); end
        tick(1);
        n_tests++; if ({ped_overdue, ped_wait_cnt} !== {1'b1, 5'd15}) begin n_fail++; $display("FAIL overdue_15 got=%b/%0d exp=1/15", ped_overdue, ped_wait_cnt); end
        tick(21);
        n_tests++; if ({ped_overdue, ped_wait_cnt} !== {1'b1, 5'd31}) begin n_fail++; $display("FAIL overdue_sat got=%b/%0d exp=1/31", ped_overdue, ped_wait_cnt); end
        walk = 1'b1;
        tick(1);
        n_tests++; if ({ped_overdue, Pedestrian, ped_wait_cnt} !== {2'b00, 5'd31}) begin n_fail++; $display("FAIL overdue_walk got=%b%b/%0d exp=00/31", ped_overdue, Pedestrian, ped_wait_cnt); end
        walk = 1'b0;
        tick(1);
    endtask

    task automatic test_held_button;
        ped_btn_raw = 1'b1;
        tick(6);
        n_tests++; if (Pedestrian !== 1'b1) begin n_fail++; $display("FAIL held_req got=%b exp=1", Pedestrian); end
        walk = 1'b1;
        tick(3);
        walk = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            n_tests++; if (Pedestrian !== 1'b0) begin n_fail++; $display("FAIL held_no_rerequest cycle=%0d got=%b exp=0", i, Pedestrian); end
        end
        ped_btn_raw = 1'b0;
        tick(6);
    endtask

    task automatic test_walk_blocks;
        walk = 1'b1;
        ped_btn_raw = 1'b1;
        tick(9);
        walk = 1'b0;
        tick(2);
        n_tests++; if (Pedestrian !== 1'b0) begin n_fail++; $display("FAIL walk_wins got=%b exp=0", Pedestrian); end
        ped_btn_raw = 1'b0;
        tick(6);
    endtask

    task automatic test_reset_mid;
        ns_sensor_raw = 1'b1;
        ew_sensor_raw = 1'b1;
        ped_btn_raw = 1'b1;
        tick(13);
        n_tests++; if ({Pedestrian, ped_wait_cnt, NS, EW} !== {1'b1, 5'd7, 2'b11}) begin n_fail++; $display("FAIL mid_pending got=%b/%0d/%b%b exp=1/7/11", Pedestrian, ped_wait_cnt, NS, EW); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if ({Pedestrian, ped_wait_cnt, NS, EW} !== 8'd0) begin n_fail++; $display("FAIL mid_async_rst got=%b/%0d/%b%b exp=0/0/00", Pedestrian, ped_wait_cnt, NS, EW); end
        #1 rst = 1'b0;
        tick(5);
        n_tests++; if ({NS, EW, Pedestrian} !== 3'b000) begin n_fail++; $display("FAIL post_rst_edge4 got=%b exp=000", {NS, EW, Pedestrian}); end
        tick(1);
        n_tests++; if ({NS, EW, Pedestrian} !== 3'b111) begin n_fail++; $display("FAIL post_rst_edge5 got=%b exp=111", {NS, EW, Pedestrian}); end
    endtask

    initial begin
        test_reset;
        test_ns_debounce;
        test_ped_request;
        test_again;
        test_overdue;
        test_held_button;
        test_walk_blocks;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
